ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: it sends one command byte, such as LED set (0xED) or reset (0xFF), from the FPGA to the keyboard. It runs in the `clk_sys` domain beside the existing PS/2 keyboard receiver and shares the same open-drain `PS2_CLOCK`/`PS2_DATA` pins. It drives the request-to-send sequence, shifts out the frame on device-generated clocks, and checks the device acknowledge. While it is busy, it flags the receiver so the receiver ignores the line.

---
 rtl/ps2_host_tx.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device command transmitter: request-to-send, frame
//            shift on device clocks, device ACK check, watchdog.
//            Optional feature macro: PS2_HOST_TX_ACK_CHECK_EN (ACK sampling).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int CLK_SYS_FREQ = 33333333,
    parameter int INHIBIT_US   = 100,
    parameter int TIMEOUT_US   = 15000,
    parameter int FILTER_LEN   = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int C_CYC_US          = CLK_SYS_FREQ / 1000000;
    localparam int C_INHIBIT_CYCLES  = C_CYC_US * INHIBIT_US;
    localparam int C_TIMEOUT_CYCLES  = C_CYC_US * TIMEOUT_US;
    localparam int C_INH_W           = $clog2(C_INHIBIT_CYCLES) + 1;
    localparam int C_TMO_W           = $clog2(C_TIMEOUT_CYCLES) + 1;
    localparam int C_TMR_W           = (C_INH_W > C_TMO_W) ? C_INH_W : C_TMO_W;
    localparam int C_FLT_W           = $clog2(FILTER_LEN) + 1;

    localparam logic [C_TMR_W-1:0] C_INH_LAST = C_TMR_W'(C_INHIBIT_CYCLES - 1);
    localparam logic [C_TMR_W-1:0] C_TMO_LAST = C_TMR_W'(C_TIMEOUT_CYCLES - 1);
    localparam logic [C_TMR_W-1:0] C_TMR_ONE  = C_TMR_W'(1);
    localparam logic [C_FLT_W-1:0] C_FLT_LAST = C_FLT_W'(FILTER_LEN - 1);
    localparam logic [C_FLT_W-1:0] C_FLT_ONE  = C_FLT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_REQ      = 3'd2,
        S_SHIFT    = 3'd3,
        S_ACK      = 3'd4,
        S_WAITIDLE = 3'd5,
        S_DONE     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    logic [1:0]         clk_sync_q;
    logic [1:0]         data_sync_q;
    logic               clk_filt_q;
    logic [C_FLT_W-1:0] flt_cnt_q;
    logic               fall_q;

    state_t             state_q;
    logic [7:0]         shreg_q;
    logic               par_q;
    logic [3:0]         bitcnt_q;
    logic [C_TMR_W-1:0] tmr_q;
    logic               wdog_expired;

    // Idle line is high, so sync and filter flops come out of reset at 1.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            flt_cnt_q   <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            fall_q      <= 1'b0;
            if (clk_sync_q[1] == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == C_FLT_LAST) begin
                clk_filt_q <= clk_sync_q[1];
                flt_cnt_q  <= '0;
                fall_q     <= clk_filt_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + C_FLT_ONE;
            end
        end
    end

    assign wdog_expired = (tmr_q == C_TMO_LAST);
    assign tx_ready     = (state_q == S_IDLE);
    assign tx_busy      = (state_q != S_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            bitcnt_q    <= '0;
            tmr_q       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid) begin
                        shreg_q    <= tx_data;
                        par_q      <= ~^tx_data;
                        bitcnt_q   <= '0;
                        tmr_q      <= '0;
                        ps2_clk_oe <= 1'b1;
                        state_q    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (tmr_q == C_INH_LAST) begin
                        tmr_q       <= '0;
                        ps2_data_oe <= 1'b1;
                        state_q     <= S_REQ;
                    end else begin
                        tmr_q <= tmr_q + C_TMR_ONE;
                    end
                end
                S_REQ: begin
                    ps2_clk_oe <= 1'b0;
                    tmr_q      <= '0;
                    state_q    <= S_SHIFT;
                end
                S_SHIFT: begin
                    // A fall in the same cycle as expiry wins and clears the watchdog.
                    if (fall_q) begin
                        tmr_q    <= '0;
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (bitcnt_q < 4'd8) begin
                            ps2_data_oe <= ~shreg_q[bitcnt_q[2:0]];
                        end else if (bitcnt_q == 4'd8) begin
                            ps2_data_oe <= ~par_q;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state_q     <= S_ACK;
                        end
                    end else if (wdog_expired) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        state_q     <= S_ERR;
                    end else begin
                        tmr_q <= tmr_q + C_TMR_ONE;
                    end
                end
                S_ACK: begin
                    if (fall_q) begin
                        tmr_q <= '0;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
                        if (data_sync_q[1]) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b0;
                            tx_error    <= 1'b1;
                            state_q     <= S_ERR;
                        end else begin
                            state_q <= S_WAITIDLE;
                        end
`else
                        tx_done <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end else if (wdog_expired) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        state_q     <= S_ERR;
                    end else begin
                        tmr_q <= tmr_q + C_TMR_ONE;
                    end
                end
                S_WAITIDLE: begin
                    if (fall_q) begin
                        tmr_q <= '0;
                    end else if (clk_filt_q && data_sync_q[1]) begin
                        tx_done <= 1'b1;
                        state_q <= S_DONE;
                    end else if (wdog_expired) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        state_q     <= S_ERR;
                    end else begin
                        tmr_q <= tmr_q + C_TMR_ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx with a PS/2 device model.
//            Expectations follow PS2_HOST_TX_ACK_CHECK_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    // Scaled-down timing keeps the run short: 2 cycles per microsecond.
    localparam int P_FREQ   = 2000000;
    localparam int P_INH_US = 100;
    localparam int P_TMO_US = 400;
    localparam int P_FLT    = 4;
    localparam int CYC_US   = P_FREQ / 1000000;
    localparam int INH_CYC  = CYC_US * P_INH_US;
    localparam int TMO_CYC  = CYC_US * P_TMO_US;
    localparam int HALF     = 30;

    logic       clk;
    logic       reset_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    wire        ps2_clk_in;
    wire        ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk_rel;
    logic       dev_data_pull;

    int         n_chk;
    int         n_fail;
    int         done_cnt;
    int         err_cnt;
    int         acc_cnt;
    int         m_phase;
    bit         prev_acc;
    logic [10:0] dev_bits;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk_rel;
    assign ps2_data_in = ~ps2_data_oe & ~dev_data_pull;

    ps2_host_tx #(
        .CLK_SYS_FREQ (P_FREQ),
        .INHIBIT_US   (P_INH_US),
        .TIMEOUT_US   (P_TMO_US),
        .FILTER_LEN   (P_FLT)
    ) dut (
        .clk_sys     (clk),
        .reset_n     (reset_n),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        n_chk++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, v, lo, hi, $time);
        end
    endtask

    // Wire image of a frame: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int          ones;
        f    = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones  += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Transaction-level model: idle until accepted, busy until the
    // completion pulse, ready again the cycle after the pulse.
    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_clk_oe", ps2_clk_oe, 0);
            check("rst_data_oe", ps2_data_oe, 0);
            check("rst_busy", tx_busy, 0);
            check("rst_ready", tx_ready, 1);
            check("rst_pulses", {tx_done, tx_error}, 0);
            m_phase  = 0;
            prev_acc = 1'b0;
        end else begin
            check("ready", tx_ready, (m_phase == 0));
            check("busy", tx_busy, (m_phase != 0));
            check("pulse_excl", tx_done & tx_error, 0);
            if (prev_acc) check("clk_pull_latency", ps2_clk_oe, 1);
            if (m_phase == 0) begin
                check("idle_clk_oe", ps2_clk_oe, 0);
                check("idle_data_oe", ps2_data_oe, 0);
                check("idle_pulse", {tx_done, tx_error}, 0);
            end
            if (tx_done === 1'b1) done_cnt++;
            if (tx_error === 1'b1) err_cnt++;
            prev_acc = 1'b0;
            if (m_phase == 0) begin
                if (tx_valid) begin
                    m_phase  = 1;
                    prev_acc = 1'b1;
                    acc_cnt++;
                end
            end else if (tx_done === 1'b1 || tx_error === 1'b1) begin
                m_phase = 0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    // Device side: measures the inhibit, then clocks nfall pulses, reading
    // the wire just before each rising edge and optionally ACKing.
    task automatic dev_frame(input int nfall, input bit ack_low, output logic [10:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check_range("inhibit_start", n, 0, 1999);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check_range("inhibit_hold", n, INH_CYC, INH_CYC + 1);
        check("start_before_release", ps2_data_oe, 1);
        repeat (HALF) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int i = 1; i <= nfall; i++) begin
            dev_clk_rel = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i <= 10) bits[i] = ps2_data_in;
            dev_clk_rel = 1'b1;
            if (i == 10) dev_data_pull = ack_low;
            repeat (HALF) @(negedge clk);
        end
        dev_data_pull = 1'b0;
        if (nfall > 10) repeat (HALF) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit ack_low,
                             input int exp_done, input int exp_err);
        int d0;
        int e0;
        int n;
        d0 = done_cnt;
        e0 = err_cnt;
        fork
            send(b);
            dev_frame(11, ack_low, dev_bits);
        join
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 1000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check({tag, "_bits"}, dev_bits, frame_of(b));
        check({tag, "_done"}, done_cnt - d0, exp_done);
        check({tag, "_err"}, err_cnt - e0, exp_err);
        check({tag, "_ready"}, tx_ready, 1);
    endtask

    task automatic timeout_test();
        int n;
        fork
            send(8'hA5);
            begin
                n = 0;
                while (ps2_clk_oe !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
                n = 0;
                while (ps2_clk_oe === 1'b1 && n < 2000) begin @(negedge clk); n++; end
                n = 0;
                while (tx_error !== 1'b1 && n < TMO_CYC + 100) begin @(negedge clk); n++; end
                check_range("timeout_cycles", n, TMO_CYC - 2, TMO_CYC + 2);
            end
        join
        repeat (3) @(negedge clk);
        check("timeout_clk_oe", ps2_clk_oe, 0);
        check("timeout_data_oe", ps2_data_oe, 0);
        check("timeout_ready", tx_ready, 1);
    endtask

    task automatic held_valid_test();
        int k;
        int d0;
        int a0;
        d0 = done_cnt;
        a0 = acc_cnt;
        fork
            begin
                @(posedge clk); #1;
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
                k = 0;
                while (k < 3000) begin
                    @(posedge clk); #1;
                    if (tx_done === 1'b1 || tx_error === 1'b1) break;
                    tx_data = tx_data + 8'h35;
                    k++;
                end
                tx_valid = 1'b0;
            end
            dev_frame(11, 1'b1, dev_bits);
        join
        repeat (5) @(negedge clk);
        check("held_bits", dev_bits, frame_of(8'h3C));
        check("held_accepts", acc_cnt - a0, 1);
        check("held_done", done_cnt - d0, 1);
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        done_cnt      = 0;
        err_cnt       = 0;
        acc_cnt       = 0;
        m_phase       = 0;
        prev_acc      = 1'b0;
        reset_n       = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        dev_clk_rel   = 1'b1;
        dev_data_pull = 1'b0;
        dev_bits      = '0;

        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_ready", tx_ready, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("reset_pulses", {tx_done, tx_error}, 2'b00);

        // Device clock pulse while idle must not start anything.
        dev_clk_rel = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk_rel = 1'b1;
        repeat (HALF) @(negedge clk);
        check("idle_devclk_busy", tx_busy, 0);

        run_frame("ed", 8'hED, 1'b1, 1, 0);
        check("ed_literal", dev_bits, 11'b11111011010);

        run_frame("zero", 8'h00, 1'b1, 1, 0);
        check("zero_literal", dev_bits, 11'b11000000000);

`ifdef PS2_HOST_TX_ACK_CHECK_EN
        run_frame("nack", 8'h5A, 1'b0, 0, 1);
`else
        run_frame("nack", 8'h5A, 1'b0, 1, 0);
`endif

        timeout_test();

        // Abort after the fourth device clock, then a clean frame.
        fork
            send(8'h00);
            dev_frame(4, 1'b0, dev_bits);
        join
        check("abort_bits", dev_bits[4:0], 5'b00000);
        check("abort_pre_data_oe", ps2_data_oe, 1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_clk_oe", ps2_clk_oe, 0);
        check("abort_data_oe", ps2_data_oe, 0);
        check("abort_busy", tx_busy, 0);
        check("abort_pulses", {tx_done, tx_error}, 2'b00);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_ready", tx_ready, 1);
        run_frame("ff", 8'hFF, 1'b1, 1, 0);
        check("ff_literal", dev_bits, 11'b11111111110);

        held_valid_test();

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
